apb_slave_mem: RTL and testbench

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_mem.sv | 71 +++++++
 tb/tb_apb_slave_mem.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer with 64x8 register storage and programmable wait states
module apb_slave_mem #(
  parameter int         WAIT_CYCLES = 1,
  parameter logic [8:0] ADDR_LIMIT  = 9'h03F
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [8:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic       PREADY,
  output logic [7:0] PRDATA,
  output logic       PSLVERR
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t     state;
  logic [3:0] wait_cnt;
  logic [8:0] addr_q;
  logic       write_q;
  logic [7:0] wdata_q;
  logic [7:0] mem [64];
  logic       addr_err;

  assign addr_err = (addr_q > ADDR_LIMIT);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Only a true setup phase starts a transfer; a stray PENABLE is ignored.
          if (PSEL && !PENABLE) begin
            addr_q   <= PADDR;
            write_q  <= PWRITE;
            wdata_q  <= PWDATA;
            wait_cnt <= WAIT_LOAD;
            state    <= (WAIT_CYCLES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (!PSEL)                 state <= IDLE;
          else if (wait_cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          // Commit happens on the completing edge, and only if the requester is still there.
          if (PSEL && PENABLE && write_q && !addr_err) mem[addr_q[5:0]] <= wdata_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign PREADY  = (state == RESP);
  assign PSLVERR = PREADY && addr_err;
  assign PRDATA  = (PREADY && !write_q && !addr_err) ? mem[addr_q[5:0]] : 8'h00;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - scoreboard bench running three wait-state configurations side by side
module tb_apb_slave_mem;

  typedef struct {
    logic [8:0] a;
    logic [7:0] d;
    logic       e;
  } exp_t;

  logic clk = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : (g == 1) ? 1 : 3;

    logic       preset, psel, penable, pwrite;
    logic [8:0] paddr;
    logic [7:0] pwdata;
    logic       pready, pslverr;
    logic [7:0] prdata;
    logic [7:0] model [64];
    exp_t       q [$];
    exp_t       mon_e;
    bit         done = 1'b0;
    bit         rw;
    logic [8:0] ra;
    logic [7:0] rd;

    apb_slave_mem #(.WAIT_CYCLES(W), .ADDR_LIMIT(9'h03F)) dut (
      .PCLK(clk), .PRESET(preset), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready), .PRDATA(prdata), .PSLVERR(pslverr)
    );

    // Monitor: every PREADY cycle must match the oldest outstanding expectation.
    initial forever begin
      @(negedge clk);
      checks++;
      if (pready) begin
        if (q.size() == 0) begin
          failures++;
          $display("FAIL w%0d unexpected_pready got=1 exp=0", W);
        end else begin
          mon_e = q.pop_front();
          if (prdata !== mon_e.d || pslverr !== mon_e.e) begin
            failures++;
            $display("FAIL w%0d resp addr=%h got=%h/%b exp=%h/%b", W, mon_e.a, prdata, pslverr, mon_e.d, mon_e.e);
          end
        end
      end else if (pslverr !== 1'b0 || prdata !== 8'h00) begin
        failures++;
        $display("FAIL w%0d idle_outputs got=%h/%b exp=00/0", W, prdata, pslverr);
      end
    end

    task automatic idle();
      psel = 1'b0; penable = 1'b0;
      @(posedge clk) #1;
    endtask

    task automatic chk_reset();
      checks++;
      if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 8'h00) begin
        failures++;
        $display("FAIL w%0d reset_outputs got=%b/%b/%h exp=0/0/00", W, pready, pslverr, prdata);
      end
    endtask

    task automatic xfer(input bit wr, input logic [8:0] a, input logic [7:0] d, input bit tgl);
      exp_t e;
      int   n;
      e.a = a;
      e.e = (a > 9'h03F);
      e.d = (wr || e.e) ? 8'h00 : model[a[5:0]];
      q.push_back(e);
      if (wr && !e.e) model[a[5:0]] = d;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge clk) #1;
      penable = 1'b1;
      if (tgl) begin paddr = a ^ 9'h015; pwdata = ~d; end
      n = 1;
      while (!pready && n < 40) begin
        @(posedge clk) #1;
        n++;
      end
      checks++;
      if (!pready) begin
        failures++;
        $display("FAIL w%0d pready_timeout addr=%h got=0 exp=1", W, a);
      end else if (n != W + 1) begin
        failures++;
        $display("FAIL w%0d access_len addr=%h got=%0d exp=%0d", W, a, n, W + 1);
      end
      @(posedge clk) #1;
    endtask

    initial begin
      psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; preset = 1'b1;
      for (int i = 0; i < 64; i++) model[i] = 8'h00;
      repeat (2) @(posedge clk);
      #1 preset = 1'b0;
      chk_reset();

      xfer(1, 9'h010, 8'hA5, 0); idle();
      xfer(0, 9'h010, 8'h00, 0); idle();

      xfer(1, 9'h040, 8'h3C, 0); idle();
      xfer(0, 9'h000, 8'h00, 0);
      xfer(0, 9'h040, 8'h00, 0); idle();

      xfer(1, 9'h001, 8'h11, 0); xfer(1, 9'h002, 8'h22, 0); xfer(1, 9'h003, 8'h33, 0);
      xfer(0, 9'h001, 8'h00, 0); xfer(0, 9'h002, 8'h00, 0); xfer(0, 9'h003, 8'h00, 0);
      idle();

      // Stray PENABLE in IDLE must not start a transfer.
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 9'h003; pwdata = 8'hEE;
      repeat (3) @(posedge clk) #1;
      idle();
      xfer(0, 9'h003, 8'h00, 0); idle();

      if (W > 0) begin
        xfer(1, 9'h020, 8'h5E, 0); idle();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h020; pwdata = 8'h77;
        @(posedge clk) #1;
        idle();
        xfer(0, 9'h020, 8'h00, 0); idle();
      end

      xfer(1, 9'h00A, 8'h5A, 1); idle();
      xfer(0, 9'h00A, 8'h00, 0);
      xfer(0, 9'h01F, 8'h00, 0); idle();

      repeat (80) begin
        rw = 1'($urandom);
        ra = 9'($urandom_range(0, 127));
        rd = 8'($urandom);
        xfer(rw, ra, rd, 1'($urandom));
        if (1'($urandom)) idle();
      end
      idle();
      for (int i = 0; i < 64; i++) xfer(0, 9'(i), 8'h00, 0);
      idle();

      // Reset lands mid-transfer (second WAIT cycle when there is one).
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h005; pwdata = 8'hFF;
      if (W == 0) preset = 1'b1;
      else begin
        @(posedge clk) #1;
        penable = 1'b1;
        if (W > 1) @(posedge clk) #1;
        preset = 1'b1;
      end
      @(posedge clk) #1;
      preset = 1'b0; psel = 1'b0; penable = 1'b0;
      for (int i = 0; i < 64; i++) model[i] = 8'h00;
      chk_reset();
      xfer(0, 9'h005, 8'h00, 0);
      xfer(0, 9'h010, 8'h00, 0); idle();
      idle();

      checks++;
      if (q.size() != 0) begin
        failures++;
        $display("FAIL w%0d queue_drain got=%0d exp=0", W, q.size());
      end
      done = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_dut[0].done && g_dut[1].done && g_dut[2].done) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (t >= 60000) begin
      failures++;
      $display("FAIL run_timeout got=%0d exp=<60000", t);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
